// File: rtl/morse_number_receiver.sv
// Morse number receiver: times key presses into dots/dashes, collects up to
// five symbols per character, and decodes the character after a release gap.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset (priority over everything)
//   key        debounced Morse key, 1 = pressed
//   abort      synchronous cancel of the character in progress
//   number     last decoded value 0x0-0xF, held between valid pulses
//   valid      one-cycle pulse, number updated
//   error      one-cycle pulse, unrecognised or overlong pattern
//   busy       high when the receiver is not idle
//   sym_count  symbols captured in the current character, 0-5
module morse_number_receiver #(
    parameter int unsigned DOT_MAX   = 8,
    parameter int unsigned MIN_PRESS = 2,
    parameter int unsigned GAP_LEN   = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       abort,
    output logic [3:0] number,
    output logic       valid,
    output logic       error,
    output logic       busy,
    output logic [2:0] sym_count
);

    localparam int unsigned SYM_W   = 5;
    localparam int unsigned SCNT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_GAP,
        S_DECODE
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0]    gap_cnt_q,   gap_cnt_d;
    logic [SYM_W-1:0]    sym_q,       sym_d;
    logic [SCNT_W-1:0]   sym_count_q, sym_count_d;
    logic                ovf_q,       ovf_d;
    logic [3:0]          number_q,    number_d;
    logic                valid_q,     valid_d;
    logic                error_q,     error_d;
    logic                busy_q,      busy_d;
    logic [4:0]          dec_c;

    // Pattern lookup: bit 4 = recognised, bits 3:0 = value. Symbols sit in
    // the low bits with the first symbol most significant (dot = 0, dash = 1).
    function automatic logic [4:0] decode_fn(input logic [SCNT_W-1:0] len,
                                             input logic [SYM_W-1:0]  s);
        logic [4:0] r;
        r = 5'h00;
        case (len)
            3'd1: if (s[0] == 1'b0) r = 5'h1E;
            3'd2: if (s[1:0] == 2'b01) r = 5'h1A;
            3'd3: if (s[2:0] == 3'b100) r = 5'h1D;
            3'd4: begin
                case (s[3:0])
                    4'b1000: r = 5'h1B;
                    4'b1010: r = 5'h1C;
                    4'b0010: r = 5'h1F;
                    default: r = 5'h00;
                endcase
            end
            3'd5: begin
                case (s)
                    5'b11111: r = 5'h10;
                    5'b01111: r = 5'h11;
                    5'b00111: r = 5'h12;
                    5'b00011: r = 5'h13;
                    5'b00001: r = 5'h14;
                    5'b00000: r = 5'h15;
                    5'b10000: r = 5'h16;
                    5'b11000: r = 5'h17;
                    5'b11100: r = 5'h18;
                    5'b11110: r = 5'h19;
                    default:  r = 5'h00;
                endcase
            end
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign dec_c = decode_fn(sym_count_q, sym_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        press_cnt_d = press_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        sym_d       = sym_q;
        sym_count_d = sym_count_q;
        ovf_d       = ovf_q;
        number_d    = number_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key) begin
                    state_d     = S_PRESS;
                    press_cnt_d = CNT_W'(1);
                end
            end
            S_PRESS: begin
                if (key) begin
                    if (press_cnt_q != {CNT_W{1'b1}}) begin
                        press_cnt_d = press_cnt_q + CNT_W'(1);
                    end
                end else if (press_cnt_q < CNT_W'(MIN_PRESS)) begin
                    // Glitch: symbol state untouched; restart the gap only
                    // if a character is already under way.
                    gap_cnt_d = '0;
                    state_d   = (sym_count_q != '0) ? S_GAP : S_IDLE;
                end else begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                    if (sym_count_q == SCNT_W'(SYM_W)) begin
                        ovf_d = 1'b1;
                    end else begin
                        sym_d       = {sym_q[SYM_W-2:0],
                                       (press_cnt_q > CNT_W'(DOT_MAX))};
                        sym_count_d = sym_count_q + SCNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (key) begin
                    state_d     = S_PRESS;
                    press_cnt_d = CNT_W'(1);
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_W'(1);
                    if (gap_cnt_q == CNT_W'(GAP_LEN - 1)) begin
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (dec_c[4] && !ovf_q) begin
                    valid_d  = 1'b1;
                    number_d = dec_c[3:0];
                end else begin
                    error_d = 1'b1;
                end
                sym_d       = '0;
                sym_count_d = '0;
                ovf_d       = 1'b0;
                press_cnt_d = '0;
                gap_cnt_d   = '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort discards the character silently; number is kept.
        if (abort) begin
            state_d     = S_IDLE;
            press_cnt_d = '0;
            gap_cnt_d   = '0;
            sym_d       = '0;
            sym_count_d = '0;
            ovf_d       = 1'b0;
            number_d    = number_q;
            valid_d     = 1'b0;
            error_d     = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
            sym_q       <= '0;
            sym_count_q <= '0;
            ovf_q       <= 1'b0;
            number_q    <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            press_cnt_q <= press_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            sym_q       <= sym_d;
            sym_count_q <= sym_count_d;
            ovf_q       <= ovf_d;
            number_q    <= number_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
        end
    end

    assign number    = number_q;
    assign valid     = valid_q;
    assign error     = error_q;
    assign busy      = busy_q;
    assign sym_count = sym_count_q;

endmodule

// File: tb/tb_morse_number_receiver.sv
// Self-checking bench for morse_number_receiver: directed scenarios plus
// randomized characters, checked against a dot/dash string reference model.
module tb_morse_number_receiver;

    localparam int DOT_MAX   = 8;
    localparam int MIN_PRESS = 2;
    localparam int GAP_LEN   = 16;
    localparam int DASH_MAX  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] number;
    logic       valid;
    logic       error;
    logic       busy;
    logic [2:0] sym_count;

    int vectors = 0;
    int miscompares = 0;
    int exp_number = 0;
    int cur[$];
    int code_tbl[string];

    morse_number_receiver #(
        .DOT_MAX  (DOT_MAX),
        .MIN_PRESS(MIN_PRESS),
        .GAP_LEN  (GAP_LEN),
        .CNT_W    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .abort    (abort),
        .number   (number),
        .valid    (valid),
        .error    (error),
        .busy     (busy),
        .sym_count(sym_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive key to k for n clock cycles (starting and ending on a falling edge).
    task automatic hold(input logic k, input int n);
        key = k;
        repeat (n) @(negedge clk);
    endtask

    task automatic add(input int d);
        cur.push_back(d);
    endtask

    // Reference model: durations -> dot/dash string, glitches dropped.
    function automatic string pattern_of();
        string s;
        s = "";
        foreach (cur[i]) begin
            if (cur[i] >= MIN_PRESS) s = {s, (cur[i] <= DOT_MAX) ? "." : "-"};
        end
        return s;
    endfunction

    // Release the key and watch the full decode window for the expected pulse.
    task automatic expect_result(input string pat, input string tag);
        bit ev, ee;
        int len;
        len = pat.len();
        ev  = (len > 0) && (len <= 5) && code_tbl.exists(pat);
        ee  = (len > 0) && !ev;
        key = 1'b0;
        for (int i = 0; i <= GAP_LEN + 3; i++) begin
            @(negedge clk);
            if (i == GAP_LEN + 1 && ev) exp_number = code_tbl[pat];
            chk({tag, ".valid"}, 8'(valid), 8'(ev && i == GAP_LEN + 1));
            chk({tag, ".error"}, 8'(error), 8'(ee && i == GAP_LEN + 1));
            if (i == 1) begin
                chk({tag, ".sym_count"}, 8'(sym_count), 8'((len > 5) ? 5 : len));
                chk({tag, ".busy"}, 8'(busy), 8'(len > 0));
            end
            if (i == GAP_LEN + 1 || i == GAP_LEN + 3)
                chk({tag, ".number"}, 8'(number), 8'(exp_number));
            if (i == GAP_LEN + 3) begin
                chk({tag, ".sym_count_end"}, 8'(sym_count), 8'd0);
                chk({tag, ".busy_end"}, 8'(busy), 8'd0);
            end
        end
    endtask

    // Play the queued presses separated by gap released cycles, then check.
    task automatic run_char(input int gap, input string tag);
        foreach (cur[i]) begin
            if (i > 0) hold(1'b0, (gap > 0) ? gap : int'($urandom_range(12, 2)));
            hold(1'b1, cur[i]);
        end
        expect_result(pattern_of(), tag);
    endtask

    task automatic expect_quiet(input int n, input string tag);
        key = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, ".no_valid"}, 8'(valid), 8'd0);
            chk({tag, ".no_error"}, 8'(error), 8'd0);
        end
        chk({tag, ".busy"}, 8'(busy), 8'd0);
        chk({tag, ".number"}, 8'(number), 8'(exp_number));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".number"}, 8'(number), 8'd0);
        chk({tag, ".valid"}, 8'(valid), 8'd0);
        chk({tag, ".error"}, 8'(error), 8'd0);
        chk({tag, ".busy"}, 8'(busy), 8'd0);
        chk({tag, ".sym_count"}, 8'(sym_count), 8'd0);
    endtask

    initial begin
        string codes[$];
        string pat;

        code_tbl["-----"] = 0;  code_tbl[".----"] = 1;  code_tbl["..---"] = 2;
        code_tbl["...--"] = 3;  code_tbl["....-"] = 4;  code_tbl["....."] = 5;
        code_tbl["-...."] = 6;  code_tbl["--..."] = 7;  code_tbl["---.."] = 8;
        code_tbl["----."] = 9;  code_tbl["."]     = 14; code_tbl[".-"]    = 10;
        code_tbl["-.."]   = 13; code_tbl["-..."]  = 11; code_tbl["-.-."]  = 12;
        code_tbl["..-."]  = 15;
        foreach (code_tbl[k]) codes.push_back(k);

        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single 3-cycle dot -> E, 17 edges after release
        cur.delete(); add(3);
        run_char(4, "dot_e");

        // Dot then four dashes -> 1; five dashes -> 0
        cur.delete(); add(4); repeat (4) add(12);
        run_char(4, "code_1");
        cur.delete(); repeat (5) add(12);
        run_char(4, "code_0");

        // Dash dot dash dot -> C; dot dot dash dot -> F
        cur.delete(); add(12); add(4); add(12); add(4);
        run_char(4, "code_c");
        cur.delete(); add(4); add(4); add(12); add(4);
        run_char(4, "code_f");

        // Boundary: 8 cycles is a dot, 9 is a dash (lone dash is an error)
        cur.delete(); add(8);
        run_char(4, "dot_max");
        cur.delete(); add(9);
        run_char(4, "dash_min");
        cur.delete(); add(8); add(9);
        run_char(4, "code_a");

        // Six dots overflow; dash-dash unrecognised
        cur.delete(); repeat (6) add(4);
        run_char(4, "six_dots");
        cur.delete(); add(12); add(12);
        run_char(4, "dash_dash");

        // Glitch from idle stays idle; glitch in a gap restarts the gap
        cur.delete(); add(1);
        run_char(4, "glitch_idle");
        cur.delete(); add(3); add(1);
        run_char(6, "glitch_gap");

        // Abort after three symbols: silent return to idle
        cur.delete(); add(4); add(4);
        foreach (cur[i]) begin
            hold(1'b1, cur[i]);
            hold(1'b0, 3);
        end
        hold(1'b1, 4);
        hold(1'b0, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort.busy", 8'(busy), 8'd0);
        chk("abort.sym_count", 8'(sym_count), 8'd0);
        expect_quiet(GAP_LEN + 6, "abort_quiet");

        // Key held across abort: counting restarts when abort falls
        key = 1'b1;
        abort = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_hold.busy", 8'(busy), 8'd0);
        abort = 1'b0;
        hold(1'b1, 8);
        expect_result(".", "abort_hold");

        // Reset mid-press discards the character and clears number
        hold(1'b1, 5);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst = 1'b1;
        exp_number = 0;
        expect_quiet(GAP_LEN + 6, "rst_quiet");

        // Randomized characters: mostly legal codes, some random patterns
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(3, 0) != 0) begin
                pat = codes[$urandom_range(codes.size() - 1, 0)];
            end else begin
                pat = "";
                for (int b = 0; b < int'($urandom_range(6, 1)); b++)
                    pat = {pat, ($urandom_range(1, 0) != 0) ? "-" : "."};
            end
            cur.delete();
            for (int b = 0; b < pat.len(); b++) begin
                if (b > 0 && $urandom_range(4, 0) == 0) add(1);
                add((pat.getc(b) == "-") ? int'($urandom_range(DASH_MAX, DOT_MAX + 1))
                                         : int'($urandom_range(DOT_MAX, MIN_PRESS)));
            end
            run_char(0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/morse_number_receiver.md
MORSE_NUMBER_RECEIVER -- requirements
Module: morse_number_receiver

Interface
REQ-001 SHALL have parameter DOT_MAX, default 8: longest accepted press, in cycles, classified as dot.
REQ-002 SHALL have parameter MIN_PRESS, default 2: presses shorter than this many cycles are glitches.
REQ-003 SHALL have parameter GAP_LEN, default 16: released cycles that end a character.
REQ-004 SHALL have parameter CNT_W, default 8: press/gap counter width.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port key  input  1  debounced Morse key, 1 = pressed.
REQ-008 SHALL have port abort  input  1  synchronous cancel of the character in progress (game timeout/logout).
REQ-009 SHALL have port number  output  4  last decoded value 0x0-0xF.
REQ-010 SHALL have port valid  output  1  one-cycle pulse: number updated.
REQ-011 SHALL have port error  output  1  one-cycle pulse: unrecognised or overlong pattern.
REQ-012 SHALL have port busy  output  1  high when state is not IDLE.
REQ-013 SHALL have port sym_count  output  3  symbols captured in the current character, 0-5.

Function
REQ-014 SHALL implement states IDLE, PRESS, GAP and DECODE; all outputs SHALL be registered.
REQ-015 SHALL transition IDLE -> PRESS, or GAP -> PRESS, on an edge sampling key=1, loading press_cnt=1.
REQ-016 SHALL increment press_cnt in PRESS on each edge sampling key=1, saturating at 2^CNT_W-1.
REQ-017 SHALL classify a press on the PRESS edge sampling key=0: press_cnt<MIN_PRESS = glitch; MIN_PRESS..DOT_MAX = dot (0); >DOT_MAX = dash (1).
REQ-018 SHALL, on a dot/dash, shift the symbol into a 5-bit register (first symbol most significant within the length), increment sym_count, clear gap_cnt and enter GAP.
REQ-019 SHALL, on a 6th symbol, set an internal overflow flag, keep sym_count at 5, store nothing and enter GAP.
REQ-020 SHALL, on a glitch, change no symbol state; it SHALL enter GAP with gap_cnt=0 if sym_count>0, else IDLE.
REQ-021 SHALL increment gap_cnt in GAP on each edge sampling key=0, and enter DECODE on the edge where gap_cnt==GAP_LEN-1.
REQ-022 SHALL, in DECODE, assert valid (or error) for exactly one cycle on the next edge, clear the symbols, sym_count and overflow, and return to IDLE.
REQ-023 SHALL give valid/error a latency of GAP_LEN+1 edges after the release edge, provided key stays 0.
REQ-024 SHALL decode 5-symbol codes: 11111=0, 01111=1, 00111=2, 00011=3, 00001=4, 00000=5, 10000=6, 11000=7, 11100=8, 11110=9.
REQ-025 SHALL decode shorter codes: len1 0=E; len2 01=A; len3 100=D; len4 1000=B, 1010=C, 0010=F.
REQ-026 SHALL treat any other pattern/length pair, or overflow set, as error: number unchanged, valid=0.
REQ-027 SHALL hold number between valid pulses; valid and error SHALL never be high together.
REQ-028 SHALL, on abort=1 at any edge, override all other conditions: enter IDLE, clear the counters, symbols and overflow, and emit no valid/error; number SHALL be held.
REQ-029 SHALL ignore key while abort=1; a press still held when abort falls SHALL start counting from the first edge after abort falls that samples key=1.

Reset
REQ-030 SHALL, on an edge with rst=0, set state=IDLE, number=0, valid=0, error=0, busy=0, sym_count=0, and clear all counters, symbols and overflow; rst SHALL take priority over abort and key.
REQ-031 SHALL, when rst is asserted mid-character, produce no valid/error pulse for the discarded character.

Verification
REQ-032 SHALL cover: press 3 cycles, then release 17 -> valid pulse 17 edges after release, number=0xE, sym_count back to 0.
REQ-033 SHALL cover: dot then four 12-cycle dashes, 4-cycle gaps between presses -> number=1 valid; all-dash sequence -> number=0.
REQ-034 SHALL cover: dash, dot, dash, dot -> number=0xC; dot, dot, dash, dot -> number=0xF; boundary presses of exactly 8 (dot) and 9 (dash) cycles.
REQ-035 SHALL cover: six dots -> error pulse, number unchanged, valid=0; pattern dash-dash (len2 11) -> error.
REQ-036 SHALL cover: 1-cycle glitch in IDLE -> stays IDLE; 1-cycle glitch mid-gap -> gap_cnt restarts, decode delayed by the same amount.
REQ-037 SHALL cover: abort after 3 symbols -> IDLE, no pulse; rst=0 mid-press -> all outputs at reset values on the next edge.
